// File: rtl/ebpc_pkg.sv
// rtl/ebpc_pkg.sv - EBPC encoder shared sizing, symbol length codes and symbol type
package ebpc_pkg;

  localparam int DATA_W       = 8;
  localparam int MAX_SYMB_LEN = DATA_W + 3;
  localparam int ZRLE_W       = 4;
  localparam int ZRLE_MAX     = 2 ** ZRLE_W + 1;
  localparam int CNT_W        = ZRLE_W + 1;

  localparam logic [1:0] ZRLE_SINGLE = 2'b01;
  localparam logic [2:0] ZRLE_PREFIX = 3'b001;

  // Encodes the number of valid MSB-aligned bits in a symbol.
  typedef enum logic [3:0] {
    LEN_NONE        = 4'd0,
    ONE             = 4'd1,
    TWO             = 4'd2,
    THREE           = 4'd3,
    FOUR            = 4'd4,
    FIVE            = 4'd5,
    SIX             = 4'd6,
    THREE_PLUS_ZRLE = 4'd7,
    EIGHT           = 4'd8,
    NINE            = 4'd9,
    TEN             = 4'd10,
    ELEVEN          = 4'd11
  } symb_len_t;

  typedef struct packed {
    logic                    zero;
    logic [MAX_SYMB_LEN-1:0] symb;
    symb_len_t               len;
  } encoding_t;

endpackage

// File: rtl/zrle_symb_gen.sv
// rtl/zrle_symb_gen.sv - combinational zero-run length to ZRLE symbol encoder
module zrle_symb_gen
  import ebpc_pkg::*;
(
  input  logic [CNT_W-1:0] i_run_len,
  output encoding_t        o_symb
);

  logic [ZRLE_W-1:0] w_code;

  assign w_code = ZRLE_W'(i_run_len - CNT_W'(2));

  always_comb begin
    o_symb = '0;
    if (i_run_len == CNT_W'(1)) begin
      o_symb.symb = {ZRLE_SINGLE, {(MAX_SYMB_LEN-2){1'b0}}};
      o_symb.len  = TWO;
    end else begin
      o_symb.symb = {ZRLE_PREFIX, w_code, {(MAX_SYMB_LEN-3-ZRLE_W){1'b0}}};
      o_symb.len  = THREE_PLUS_ZRLE;
    end
  end

endmodule

// File: rtl/dbx_zrle.sv
// rtl/dbx_zrle.sv - zero-run-length stage between DBX compressor and bit packer
module dbx_zrle
  import ebpc_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  encoding_t symb_i,
  input  logic      last_i,
  input  logic      vld_i,
  output logic      rdy_o,
  output encoding_t symb_o,
  output logic      last_o,
  output logic      vld_o,
  input  logic      rdy_i
);

  logic [CNT_W-1:0] r_cnt;
  encoding_t        r_symb;
  logic             r_last;
  logic             r_vld;

  logic             w_free;
  logic [CNT_W-1:0] w_k;
  logic             w_term;
  logic [CNT_W-1:0] w_run_len;
  encoding_t        w_run_symb;
  logic             w_rdy;
  logic             w_load;
  encoding_t        w_load_symb;
  logic             w_load_last;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_free    = !r_vld | rdy_i;
  assign w_k       = r_cnt + CNT_W'(1);
  assign w_term    = (w_k == CNT_W'(ZRLE_MAX)) | last_i;
  // A terminating zero emits the extended run; a FLUSH emits the run held so far.
  assign w_run_len = symb_i.zero ? w_k : r_cnt;

  zrle_symb_gen u_symb_gen (
    .i_run_len (w_run_len),
    .o_symb    (w_run_symb)
  );

  always_comb begin
    w_rdy       = 1'b0;
    w_load      = 1'b0;
    w_load_symb = w_run_symb;
    w_load_last = 1'b0;
    w_cnt_nxt   = r_cnt;
    if (symb_i.zero) begin
      // Non-terminating zeros are absorbed even while the output slot is stalled.
      w_rdy = w_free | !w_term;
      if (vld_i && w_rdy) begin
        if (w_term) begin
          w_load      = 1'b1;
          w_load_last = last_i;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_k;
        end
      end
    end else if (r_cnt == '0) begin
      w_rdy = w_free;
      if (vld_i && w_free) begin
        w_load           = 1'b1;
        w_load_symb      = symb_i;
        w_load_symb.zero = 1'b0;
        w_load_last      = last_i;
      end
    end else if (vld_i && w_free) begin
      w_load    = 1'b1;
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_symb <= '0;
      r_last <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_load) begin
        r_vld  <= 1'b1;
        r_symb <= w_load_symb;
        r_last <= w_load_last;
      end else if (rdy_i) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign rdy_o  = w_rdy;
  assign symb_o = r_symb;
  assign last_o = r_last;
  assign vld_o  = r_vld;

endmodule

// File: tb/tb_dbx_zrle.sv
// tb/tb_dbx_zrle.sv - randomized self-checking bench for dbx_zrle
module tb_dbx_zrle;
  import ebpc_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  encoding_t symb_i;
  logic      last_i;
  logic      vld_i;
  logic      rdy_o;
  encoding_t symb_o;
  logic      last_o;
  logic      vld_o;
  logic      rdy_i;

  dbx_zrle u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .symb_i (symb_i),
    .last_i (last_i),
    .vld_i  (vld_i),
    .rdy_o  (rdy_o),
    .symb_o (symb_o),
    .last_o (last_o),
    .vld_o  (vld_o),
    .rdy_i  (rdy_i)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 2;  // 0 random, 1 stall, 2 always ready
  bit          gaps_en = 1'b0;
  int          w_pre;
  int          w_last;
  logic [16:0] exp_q[$];
  encoding_t   blk[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] run_word(input int k, input bit l);
    logic [MAX_SYMB_LEN-1:0] s;
    logic [3:0]              len;
    if (k == 1) begin
      s   = MAX_SYMB_LEN'(1) << (MAX_SYMB_LEN - 2);
      len = 4'd2;
    end else begin
      s   = MAX_SYMB_LEN'(16 + k - 2) << (MAX_SYMB_LEN - 7);
      len = 4'd7;
    end
    return {1'b0, s, len, l};
  endfunction

  // Reference: whole-block view of zero runs, independent of cycle timing.
  function automatic void model(input encoding_t b[$]);
    int run = 0;
    bit l;
    for (int i = 0; i < b.size(); i++) begin
      l = (i == b.size() - 1);
      if (b[i].zero) begin
        run++;
        if (run == ZRLE_MAX || l) begin
          exp_q.push_back(run_word(run, l));
          run = 0;
        end
      end else begin
        if (run > 0) exp_q.push_back(run_word(run, 1'b0));
        run = 0;
        exp_q.push_back({1'b0, b[i].symb, 4'(b[i].len), l});
      end
    end
  endfunction

  function automatic encoding_t mk(input bit z);
    encoding_t s;
    s.zero = z;
    s.symb = MAX_SYMB_LEN'($urandom);
    s.len  = symb_len_t'($urandom_range(1, 11));
    return s;
  endfunction

  task automatic send_raw(input encoding_t s, input logic l, output int w);
    bit acc = 1'b0;
    vld_i  = 1'b1;
    symb_i = s;
    last_i = l;
    w      = 0;
    while (!acc) begin
      @(negedge clk);
      acc = rdy_o;
      @(posedge clk);
      #1;
      if (!acc) begin
        w++;
        if (w > 300) begin
          check("accept_timeout", 32'(w), 32'd0);
          acc = 1'b1;
        end
      end
    end
    vld_i  = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic send_block(input encoding_t b[$]);
    int w;
    model(b);
    w_pre  = 0;
    w_last = 0;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps_en && $urandom_range(0, 3) == 0) begin
        vld_i = 1'b0;
        @(posedge clk);
        #1;
      end
      send_raw(b[i], (i == b.size() - 1), w);
      if (i == b.size() - 1) w_last = w;
      else w_pre += w;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || vld_o) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_i = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 2);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && vld_o && rdy_i) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else check("out", 32'({symb_o.zero, symb_o.symb, symb_o.len, last_o}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n  = 1'b0;
    vld_i  = 1'b0;
    last_i = 1'b0;
    symb_i = '0;
    rdy_i  = 1'b0;
    #12;
    check("rst_vld", 32'(vld_o), 32'd0);
    check("rst_symb", 32'(symb_o), 32'd0);
    check("rst_last", 32'(last_o), 32'd0);
    check("rst_rdy", 32'(rdy_o), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single zero mid-block
    blk.delete();
    blk.push_back(mk(0));
    blk.push_back(mk(1));
    for (int i = 0; i < 7; i++) blk.push_back(mk(0));
    send_block(blk);
    drain();

    // max run, then max run plus one
    for (int n = 17; n <= 18; n++) begin
      blk.delete();
      for (int i = 0; i < n; i++) blk.push_back(mk(1));
      blk.push_back(mk(0));
      send_block(blk);
      drain();
    end

    // trailing run closed by last
    blk.delete();
    for (int i = 0; i < 4; i++) blk.push_back(mk(0));
    for (int i = 0; i < 5; i++) blk.push_back(mk(1));
    send_block(blk);
    drain();
    check("trail_cnt", 32'(u_dut.r_cnt), 32'd0);

    // FLUSH costs exactly one stalled input cycle
    blk.delete();
    for (int i = 0; i < 3; i++) blk.push_back(mk(1));
    blk.push_back(mk(0));
    send_block(blk);
    check("flush_zero_waits", 32'(w_pre), 32'd0);
    check("flush_nz_waits", 32'(w_last), 32'd1);
    drain();

    // backpressure: zeros absorbed while stalled, NZ held until release
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    blk.delete();
    for (int i = 0; i < 5; i++) blk.push_back(mk(1));
    blk.push_back(mk(0));
    fork
      send_block(blk);
      begin
        repeat (10) @(negedge clk);
        rdy_mode = 2;
      end
    join
    check("bp_zero_waits", 32'(w_pre), 32'd0);
    check("bp_nz_stalled", 32'(w_last > 0), 32'd1);
    drain();

    // async reset mid-run with a pending output
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send_raw(mk(0), 1'b0, w);
    for (int i = 0; i < 6; i++) send_raw(mk(1), 1'b0, w);
    check("pre_rst_vld", 32'(vld_o), 32'd1);
    check("pre_rst_cnt", 32'(u_dut.r_cnt), 32'd6);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(vld_o), 32'd0);
    check("mid_rst_cnt", 32'(u_dut.r_cnt), 32'd0);
    #1 rst_n = 1'b1;
    rdy_mode = 2;
    blk.delete();
    for (int i = 0; i < 2; i++) blk.push_back(mk(1));
    for (int i = 0; i < 7; i++) blk.push_back(mk(0));
    send_block(blk);
    drain();

    // random blocks with random gaps and backpressure
    rdy_mode = 0;
    gaps_en  = 1'b1;
    for (int b = 0; b < 150; b++) begin
      int p = $urandom_range(0, 100);
      blk.delete();
      for (int i = 0; i < DATA_W + 1; i++) blk.push_back(mk($urandom_range(0, 99) < p));
      send_block(blk);
    end
    rdy_mode = 2;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
